// File: rtl/haz_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Holds the per-stage slot record, the forward-select code and clog2.
package haz_pkg;

    // Slot records carry the register address zero-extended to this width,
    // so one struct serves any AW up to RD_W.
    localparam int RD_W = 16;

    // Forward select meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            load;
    } slot_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/haz_src_match.sv
// Youngest-match priority encoder for one source operand.
// Ports: slots (scoreboard), src_addr/src_used (operand) -> fwd_sel, hazard.
module haz_src_match
    import haz_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SW       = 2
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic [AW-1:0]     src_addr,
    input  logic              src_used,
    output logic [SW-1:0]     fwd_sel,
    output logic              hazard
);

    logic hit;

    always_comb begin
        fwd_sel = SW'(FWD_RF);
        hazard  = 1'b0;
        hit     = 1'b0;
        if (src_used && src_addr != '0) begin
            // Scan from EX outward; the first hit is the youngest writer.
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && slots[k].valid &&
                    slots[k].rd == RD_W'(src_addr)) begin
                    hit = 1'b1;
                    // The WB slot writes through the register file.
                    if (k != DEPTH - 1)
                        fwd_sel = SW'(k + 1);
                    hazard = slots[k].load && (k < LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Forwarding / load-use scoreboard beside the ID stage.
// In: clk, reset, iss_*, src_addr, src_used, freeze, flush.
// Out: stall, fwd_sel (per source), inflight.
// Optional HAZ_PERF_CNT_EN adds stall_cycles and fwd_hits counters.
module pipe_hazard_scoreboard
    import haz_pkg::*;
#(
    parameter  int NSRC     = 2,
    parameter  int AW       = 5,
    parameter  int LOAD_LAT = 1,
    localparam int DEPTH    = LOAD_LAT + 2,
    localparam int SW       = clog2(DEPTH),
    localparam int IW       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic             iss_we,
    input  logic [AW-1:0]    iss_rd,
    input  logic             iss_load,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC-1:0]  src_used,
    input  logic             freeze,
    input  logic             flush,
    output logic             stall,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic [IW-1:0]    inflight
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      fwd_hits
`endif
);

    slot_t [DEPTH-1:0] slots;
    slot_t             new_slot;
    logic [NSRC-1:0]   haz;
    logic              issue;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        haz_src_match #(
            .AW       (AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SW       (SW)
        ) u_match (
            .slots    (slots),
            .src_addr (src_addr[g*AW +: AW]),
            .src_used (src_used[g]),
            .fwd_sel  (fwd_sel[g*SW +: SW]),
            .hazard   (haz[g])
        );
    end

    assign stall = iss_valid && !flush && (|haz);
    assign issue = iss_valid && !stall && !flush;

    // r0 writes are dropped here so they can never match a source.
    always_comb begin
        new_slot       = '0;
        new_slot.valid = issue && iss_we && (iss_rd != '0);
        if (new_slot.valid) begin
            new_slot.rd   = RD_W'(iss_rd);
            new_slot.load = iss_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots <= '0;
        end else if (!freeze) begin
            slots[0] <= new_slot;
            for (int k = 1; k < DEPTH; k++)
                slots[k] <= slots[k-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++)
            inflight = inflight + IW'(slots[k].valid);
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_inc;
    logic fwd_inc;

    assign stall_inc = stall && !freeze;
    assign fwd_inc   = issue && !freeze && (|fwd_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            fwd_hits     <= '0;
        end else begin
            if (stall_inc && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (fwd_inc && fwd_hits != '1)
                fwd_hits <= fwd_hits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard.
// Runs LOAD_LAT=1 (dut a) and LOAD_LAT=3 (dut b).
module tb_pipe_hazard_scoreboard;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // dut a: LOAD_LAT=1, DEPTH=3, SW=2
    logic       iss_valid = 0, iss_we = 0, iss_load = 0;
    logic [4:0] iss_rd = 0;
    logic [9:0] src_addr = 0;
    logic [1:0] src_used = 0;
    logic       freeze = 0, flush = 0;
    logic       stall;
    logic [3:0] fwd_sel;
    logic [1:0] inflight;

    // dut b: LOAD_LAT=3, DEPTH=5, SW=3
    logic       b_valid = 0, b_we = 0, b_load = 0;
    logic [4:0] b_rd = 0;
    logic [9:0] b_src = 0;
    logic [1:0] b_used = 0;
    logic       b_stall;
    logic [5:0] b_fwd;
    logic [2:0] b_inflight;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, fwd_hits;
    logic [31:0] b_stall_cycles, b_fwd_hits;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(.NSRC(2), .AW(5), .LOAD_LAT(1)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .iss_valid    (iss_valid),
        .iss_we       (iss_we),
        .iss_rd       (iss_rd),
        .iss_load     (iss_load),
        .src_addr     (src_addr),
        .src_used     (src_used),
        .freeze       (freeze),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .inflight     (inflight)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .fwd_hits     (fwd_hits)
`endif
    );

    pipe_hazard_scoreboard #(.NSRC(2), .AW(5), .LOAD_LAT(3)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .iss_valid    (b_valid),
        .iss_we       (b_we),
        .iss_rd       (b_rd),
        .iss_load     (b_load),
        .src_addr     (b_src),
        .src_used     (b_used),
        .freeze       (1'b0),
        .flush        (1'b0),
        .stall        (b_stall),
        .fwd_sel      (b_fwd),
        .inflight     (b_inflight)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (b_stall_cycles),
        .fwd_hits     (b_fwd_hits)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we,
                         input logic [4:0] rd, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used);
        iss_valid = v;
        iss_we    = we;
        iss_rd    = rd;
        iss_load  = ld;
        src_addr  = {s1, s0};
        src_used  = used;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic we,
                           input logic [4:0] rd, input logic ld,
                           input logic [4:0] s0, input logic [1:0] used);
        b_valid = v;
        b_we    = we;
        b_rd    = rd;
        b_load  = ld;
        b_src   = {5'd0, s0};
        b_used  = used;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (stall !== 1'b0 || fwd_sel !== 4'd0 || inflight !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got stall=%b fwd=%h inflight=%0d want 0/0/0",
                     stall, fwd_sel, inflight);
        end
        tests_run++;
        if (b_stall !== 1'b0 || b_fwd !== 6'd0 || b_inflight !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state_b: got stall=%b fwd=%h inflight=%0d want 0/0/0",
                     b_stall, b_fwd, b_inflight);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_dep();
        idle();
        drive(1, 1, 3, 0, 0, 0, 2'b00);
        tick();
        // both sources read r3, just issued -> EX/MEM for each
        drive(1, 1, 4, 0, 3, 3, 2'b11);
        tests_run++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0101) begin
            tests_failed++;
            $display("FAIL alu_dep_adj: got stall=%b fwd=%b want 0/0101",
                     stall, fwd_sel);
        end
        tick();
        idle();
        drive(1, 1, 3, 0, 0, 0, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 3, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b0 || fwd_sel !== 4'b0010 || inflight !== 2'd1) begin
            tests_failed++;
            $display("FAIL alu_dep_bubble: got stall=%b fwd=%b inflight=%0d want 0/0010/1",
                     stall, fwd_sel, inflight);
        end
        tick();
    endtask

    task automatic test_load_use();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 5, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b want 1", stall);
        end
        tick();
        tests_run++;
        if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2) begin
            tests_failed++;
            $display("FAIL load_use_release: got stall=%b fwd0=%0d want 0/2",
                     stall, fwd_sel[1:0]);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
`ifdef HAZ_PERF_CNT_EN
        tests_run++;
        if (stall_cycles !== 32'd1 || fwd_hits !== 32'd1) begin
            tests_failed++;
            $display("FAIL perf_cnt: got stall_cycles=%0d fwd_hits=%0d want 1/1",
                     stall_cycles, fwd_hits);
        end
`endif
    endtask

    task automatic test_load_use_lat3();
        drive_b(1, 1, 5, 1, 0, 2'b00);
        tick();
        drive_b(1, 0, 0, 0, 5, 2'b01);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (b_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL lat3_stall%0d: got %b want 1", c, b_stall);
            end
            tick();
        end
        tests_run++;
        if (b_stall !== 1'b0 || b_fwd[2:0] !== 3'd4) begin
            tests_failed++;
            $display("FAIL lat3_release: got stall=%b fwd0=%0d want 0/4",
                     b_stall, b_fwd[2:0]);
        end
        tick();
        drive_b(0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic test_youngest();
        idle();
        drive(1, 1, 7, 0, 0, 0, 2'b00);
        tick();
        drive(1, 1, 7, 0, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 7, 0, 2'b01);
        tests_run++;
        if (fwd_sel[1:0] !== 2'd1) begin
            tests_failed++;
            $display("FAIL youngest_wins: got %0d want 1", fwd_sel[1:0]);
        end
        tick();
        idle();
        drive(1, 1, 0, 0, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 0, 0, 2'b01);
        tests_run++;
        if (inflight !== 2'd0 || fwd_sel !== 4'd0) begin
            tests_failed++;
            $display("FAIL r0_untracked: got inflight=%0d fwd=%h want 0/0",
                     inflight, fwd_sel);
        end
        tick();
    endtask

    task automatic test_retire();
        idle();
        drive(1, 1, 9, 0, 0, 0, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        drive(1, 0, 0, 0, 9, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b0 || fwd_sel !== 4'd0 || inflight !== 2'd1) begin
            tests_failed++;
            $display("FAIL retire_wb: got stall=%b fwd=%h inflight=%0d want 0/0/1",
                     stall, fwd_sel, inflight);
        end
        tick();
        idle();
        drive(1, 1, 10, 1, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 10, 10, 2'b00);
        tests_run++;
        if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
            tests_failed++;
            $display("FAIL src_unused: got stall=%b fwd=%h want 0/0",
                     stall, fwd_sel);
        end
        drive(1, 0, 0, 0, 0, 10, 2'b10);
        tests_run++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0100) begin
            tests_failed++;
            $display("FAIL src1_used: got stall=%b fwd=%b want 1/0100",
                     stall, fwd_sel);
        end
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
    endtask

    task automatic test_freeze();
        idle();
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        freeze = 1'b1;
        drive(1, 0, 0, 0, 5, 0, 2'b01);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (stall !== 1'b1 || inflight !== 2'd1) begin
                tests_failed++;
                $display("FAIL freeze_hold%0d: got stall=%b inflight=%0d want 1/1",
                         c, stall, inflight);
            end
            tick();
        end
        freeze = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_drop: got %b want 1", stall);
        end
        tick();
        tests_run++;
        if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2 || inflight !== 2'd1) begin
            tests_failed++;
            $display("FAIL freeze_after: got stall=%b fwd0=%0d inflight=%0d want 0/2/1",
                     stall, fwd_sel[1:0], inflight);
        end
        tick();
    endtask

    task automatic test_flush();
        idle();
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        flush = 1'b1;
        drive(1, 1, 6, 0, 5, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tests_run++;
        if (inflight !== 2'd1) begin
            tests_failed++;
            $display("FAIL flush_bubble: got inflight=%0d want 1", inflight);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        drive(1, 1, 5, 1, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 5, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_load_stall: got %b want 1", stall);
        end
        tick();
        tests_run++;
        if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2) begin
            tests_failed++;
            $display("FAIL b2b_load_fwd: got stall=%b fwd0=%0d want 0/2",
                     stall, fwd_sel[1:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        drive(1, 1, 1, 0, 0, 0, 2'b00);
        tick();
        drive(1, 1, 2, 0, 0, 0, 2'b00);
        tick();
        drive(1, 1, 3, 1, 0, 0, 2'b00);
        tick();
        drive(1, 0, 0, 0, 3, 0, 2'b01);
        tests_run++;
        if (stall !== 1'b1 || inflight !== 2'd3) begin
            tests_failed++;
            $display("FAIL pre_reset: got stall=%b inflight=%0d want 1/3",
                     stall, inflight);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0 || inflight !== 2'd0 || fwd_sel !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got stall=%b inflight=%0d fwd=%h want 0/0/0",
                     stall, inflight, fwd_sel);
        end
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_dep();
        test_load_use();
        test_load_use_lat3();
        test_youngest();
        test_retire();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
